// File: rtl/ula_multiciclo_if.sv
// Handshake and data bundle between the control unit and the multicycle ALU.
interface ula_multiciclo_if #(
   parameter int WIDTH = 8
);
   logic             enable;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] regA;
   logic [WIDTH-1:0] regB;
   logic [WIDTH-1:0] saidaULA;
   logic [WIDTH-1:0] saidaAlta;
   logic             busy;
   logic             pronto;
   logic             zero;
   logic             carry;
   logic             overflow;
   logic             erroDiv;

   modport master (
      output enable, opcode, regA, regB,
      input  saidaULA, saidaAlta, busy, pronto, zero, carry, overflow, erroDiv
   );

   modport slave (
      input  enable, opcode, regA, regB,
      output saidaULA, saidaAlta, busy, pronto, zero, carry, overflow, erroDiv
   );
endinterface

// File: rtl/ula_multiciclo.sv
// Multicycle ALU: single-cycle logic/add/sub, iterative shift-add multiply
// and restoring divide, with enable/busy/pronto handshake and status flags.
module ula_multiciclo #(
   parameter int WIDTH = 8
) (
   input logic             clock,
   input logic             reset,
   ula_multiciclo_if.slave bus
);
   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [3:0] OP_ZERO = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_MUL  = 4'b0011;
   localparam logic [3:0] OP_DIV  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_NOT  = 4'b0111;
   localparam logic [3:0] OP_XOR  = 4'b1000;
   localparam logic [3:0] OP_XNOR = 4'b1001;
   localparam logic [3:0] OP_PSA  = 4'b1010;
   localparam logic [3:0] OP_PSB  = 4'b1011;

   typedef enum logic {OCIOSO, ITERA} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             op_div;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   // MUL: work_hi = running high half, work_lo = multiplier shifting out / product low.
   // DIV: work_hi = partial remainder, work_lo = dividend shifting out / quotient in.
   logic [WIDTH-1:0] work_hi;
   logic [WIDTH-1:0] work_lo;

   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;
   logic [WIDTH-1:0] sc_res;
   logic             sc_carry;
   logic             sc_ovf;
   logic             is_multi;
   logic             is_nop;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_trial;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;

   // Single-cycle result and flags straight from the bus operands
   always_comb begin
      add_full = {1'b0, bus.regA} + {1'b0, bus.regB};
      sub_full = {1'b0, bus.regA} - {1'b0, bus.regB};
      sc_res   = '0;
      sc_carry = 1'b0;
      sc_ovf   = 1'b0;
      is_multi = (bus.opcode == OP_MUL) || (bus.opcode == OP_DIV);
      is_nop   = (bus.opcode[3:2] == 2'b11);
      case (bus.opcode)
         OP_ZERO: sc_res = '0;
         OP_ADD: begin
            sc_res   = add_full[WIDTH-1:0];
            sc_carry = add_full[WIDTH];
            sc_ovf   = (bus.regA[WIDTH-1] == bus.regB[WIDTH-1]) &&
                       (add_full[WIDTH-1] != bus.regA[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res   = sub_full[WIDTH-1:0];
            sc_carry = sub_full[WIDTH];   // borrow: wraps only when A < B
            sc_ovf   = (bus.regA[WIDTH-1] != bus.regB[WIDTH-1]) &&
                       (sub_full[WIDTH-1] != bus.regA[WIDTH-1]);
         end
         OP_AND:  sc_res = bus.regA & bus.regB;
         OP_OR:   sc_res = bus.regA | bus.regB;
         OP_NOT:  sc_res = ~bus.regA;
         OP_XOR:  sc_res = bus.regA ^ bus.regB;
         OP_XNOR: sc_res = ~(bus.regA ^ bus.regB);
         OP_PSA:  sc_res = bus.regA;
         OP_PSB:  sc_res = bus.regB;
         default: sc_res = '0;
      endcase
   end

   // One multiply or divide step applied to the working registers
   always_comb begin
      mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_reg} : '0);
      div_shift = {work_hi, work_lo[WIDTH-1]};
      div_trial = div_shift - {1'b0, b_reg};
      if (op_div) begin
         if (!div_trial[WIDTH]) begin
            step_hi = div_trial[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
      end
   end

   // Control FSM with registered results, flags and handshake outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= OCIOSO;
         cnt           <= '0;
         op_div        <= 1'b0;
         a_reg         <= '0;
         b_reg         <= '0;
         work_hi       <= '0;
         work_lo       <= '0;
         bus.saidaULA  <= '0;
         bus.saidaAlta <= '0;
         bus.busy      <= 1'b0;
         bus.pronto    <= 1'b0;
         bus.zero      <= 1'b0;
         bus.carry     <= 1'b0;
         bus.overflow  <= 1'b0;
         bus.erroDiv   <= 1'b0;
      end else begin
         bus.pronto <= 1'b0;
         case (state)
            OCIOSO: begin
               if (bus.enable) begin
                  if (is_multi) begin
                     state    <= ITERA;
                     bus.busy <= 1'b1;
                     cnt      <= '0;
                     op_div   <= (bus.opcode == OP_DIV);
                     a_reg    <= bus.regA;
                     b_reg    <= bus.regB;
                     work_hi  <= '0;
                     work_lo  <= (bus.opcode == OP_DIV) ? bus.regA : bus.regB;
                  end else begin
                     bus.pronto <= 1'b1;
                     if (!is_nop) begin
                        bus.saidaULA  <= sc_res;
                        bus.saidaAlta <= '0;
                        bus.zero      <= (sc_res == '0);
                        bus.carry     <= sc_carry;
                        bus.overflow  <= sc_ovf;
                        bus.erroDiv   <= 1'b0;
                     end
                  end
               end
            end
            ITERA: begin
               work_hi <= step_hi;
               work_lo <= step_lo;
               cnt     <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state        <= OCIOSO;
                  bus.busy     <= 1'b0;
                  bus.pronto   <= 1'b1;
                  bus.carry    <= 1'b0;
                  if (op_div && (b_reg == '0)) begin
                     bus.saidaULA  <= '1;
                     bus.saidaAlta <= a_reg;
                     bus.zero      <= 1'b0;
                     bus.overflow  <= 1'b0;
                     bus.erroDiv   <= 1'b1;
                  end else begin
                     bus.saidaULA  <= step_lo;
                     bus.saidaAlta <= step_hi;
                     bus.zero      <= (step_lo == '0);
                     bus.overflow  <= !op_div && (step_hi != '0);
                     bus.erroDiv   <= 1'b0;
                  end
               end
            end
            default: state <= OCIOSO;
         endcase
      end
   end
endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo with a behavioural arithmetic model.
module tb_ula_multiciclo;
   localparam int W  = 8;
   localparam int RW = 2 * W + 4;
   typedef logic [RW-1:0] res_t;   // {saidaULA, saidaAlta, zero, carry, overflow, erroDiv}

   logic clock = 1'b0;
   logic reset = 1'b1;

   ula_multiciclo_if #(.WIDTH(W)) bus ();
   ula_multiciclo #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int   n_tests = 0;
   int   n_fail  = 0;
   res_t model_state = '0;
   logic [3:0] sc_ops [10] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};

   function automatic longint sval(input logic [W-1:0] x);
      longint v = longint'(x);
      if (v >= (longint'(1) << (W - 1))) v = v - (longint'(1) << W);
      return v;
   endfunction

   // Reference: plain arithmetic on unsigned/signed integers
   function automatic res_t model_op(input logic [3:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input res_t prev);
      longint lim = longint'(1) << W;
      longint ua  = longint'(a);
      longint ub  = longint'(b);
      longint lo  = 0;
      longint hi  = 0;
      longint s   = 0;
      bit c = 1'b0, o = 1'b0, e = 1'b0;
      case (op)
         4'd0:  lo = 0;
         4'd1:  begin lo = (ua + ub) % lim; c = (ua + ub) >= lim;
                      s = sval(a) + sval(b); o = (s >= lim / 2) || (s < -(lim / 2)); end
         4'd2:  begin lo = (ua - ub + lim) % lim; c = ua < ub;
                      s = sval(a) - sval(b); o = (s >= lim / 2) || (s < -(lim / 2)); end
         4'd3:  begin lo = (ua * ub) % lim; hi = (ua * ub) / lim; o = hi != 0; end
         4'd4:  if (ub == 0) begin lo = lim - 1; hi = ua; e = 1'b1; end
                else begin lo = ua / ub; hi = ua % ub; end
         4'd5:  lo = ua & ub;
         4'd6:  lo = ua | ub;
         4'd7:  lo = (lim - 1) - ua;
         4'd8:  lo = ua ^ ub;
         4'd9:  lo = (lim - 1) - (ua ^ ub);
         4'd10: lo = ua;
         4'd11: lo = ub;
         default: return prev;
      endcase
      return {W'(lo), W'(hi), lo == 0, c, o, e};
   endfunction

   function automatic res_t observe();
      return {bus.saidaULA, bus.saidaAlta, bus.zero, bus.carry, bus.overflow, bus.erroDiv};
   endfunction

   // Launch one operation and count negedges until pronto (bounded)
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
      @(negedge clock);
      bus.enable = 1'b1; bus.opcode = op; bus.regA = a; bus.regB = b;
      @(posedge clock);
      #1 bus.enable = 1'b0;
      lat = -1;
      for (int i = 1; i <= 4 * W; i++) begin
         @(negedge clock);
         if (bus.pronto) begin lat = i; break; end
      end
   endtask

   task automatic test_reset();
      bus.enable = 1'b1; bus.opcode = 4'b0001; bus.regA = 8'hFF; bus.regB = 8'h01;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_tests++;
      if (observe() !== res_t'(0)) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", observe(), res_t'(0)); end
      n_tests++;
      if (bus.pronto !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_handshake: got pronto=%b busy=%b want 0 0", bus.pronto, bus.busy);
      end
      reset = 1'b0; bus.enable = 1'b0;
      model_state = '0;
      $display("[TB] reset checked");
   endtask

   task automatic test_add_sub();
      int   lat;
      res_t exp;
      run_op(4'b0001, 8'hFF, 8'h01, lat);
      n_tests++;
      if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", lat); end
      exp = {8'h00, 8'h00, 4'b1100};
      n_tests++;
      if (observe() !== exp) begin n_fail++; $display("FAIL add_ff_01: got %h want %h", observe(), exp); end
      @(negedge clock);
      n_tests++;
      if (bus.pronto !== 1'b0) begin n_fail++; $display("FAIL add_pronto_pulse: got %b want 0", bus.pronto); end
      run_op(4'b0010, 8'h80, 8'h01, lat);
      exp = {8'h7F, 8'h00, 4'b0010};
      n_tests++;
      if (observe() !== exp || lat !== 1) begin
         n_fail++; $display("FAIL sub_80_01: got %h lat %0d want %h lat 1", observe(), lat, exp);
      end
      model_state = exp;
      for (int i = 0; i < 24; i++) begin
         logic [3:0]   op = sc_ops[$urandom_range(0, 9)];
         logic [W-1:0] a  = W'($urandom());
         logic [W-1:0] b  = W'($urandom());
         exp = model_op(op, a, b, model_state);
         run_op(op, a, b, lat);
         n_tests++;
         if (observe() !== exp || lat !== 1) begin
            n_fail++; $display("FAIL single_rand op=%h a=%h b=%h: got %h lat %0d want %h lat 1", op, a, b, observe(), lat, exp);
         end
         model_state = exp;
         $display("[TB] single op=%h a=%h b=%h -> %h", op, a, b, observe());
      end
   endtask

   task automatic test_mul();
      int   lat = -1;
      res_t exp;
      @(negedge clock);
      bus.enable = 1'b1; bus.opcode = 4'b0011; bus.regA = 8'hFF; bus.regB = 8'hFF;
      @(posedge clock);
      #1 bus.opcode = 4'b0001; bus.regA = 8'h01; bus.regB = 8'h01;   // ignored while busy
      for (int i = 1; i <= 4 * W; i++) begin
         @(negedge clock);
         if (i == 1) begin
            n_tests++;
            if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy: got %b want 1", bus.busy); end
         end
         if (i == 3) bus.enable = 1'b0;
         if (bus.pronto) begin lat = i; break; end
      end
      n_tests++;
      if (lat !== W + 1) begin n_fail++; $display("FAIL mul_latency: got %0d want %0d", lat, W + 1); end
      exp = {8'h01, 8'hFE, 4'b0010};
      n_tests++;
      if (observe() !== exp || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL mul_ff_ff: got %h busy %b want %h busy 0", observe(), bus.busy, exp);
      end
      model_state = exp;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_tests++;
         if (bus.pronto !== 1'b0) begin n_fail++; $display("FAIL mul_ignored_enable: got pronto %b want 0", bus.pronto); end
      end
      for (int i = 0; i < 12; i++) begin
         logic [3:0]   op = ($urandom_range(0, 1) == 0) ? 4'd3 : 4'd4;
         logic [W-1:0] a  = W'($urandom());
         logic [W-1:0] b  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom());
         exp = model_op(op, a, b, model_state);
         run_op(op, a, b, lat);
         n_tests++;
         if (observe() !== exp || lat !== W + 1) begin
            n_fail++; $display("FAIL multi_rand op=%h a=%h b=%h: got %h lat %0d want %h lat %0d", op, a, b, observe(), lat, exp, W + 1);
         end
         model_state = exp;
         $display("[TB] multi op=%h a=%h b=%h -> %h", op, a, b, observe());
      end
   endtask

   task automatic test_div();
      int   lat;
      res_t exp;
      run_op(4'b0100, 8'd200, 8'd7, lat);
      exp = {8'd28, 8'd4, 4'b0000};
      n_tests++;
      if (observe() !== exp || lat !== W + 1) begin
         n_fail++; $display("FAIL div_200_7: got %h lat %0d want %h lat %0d", observe(), lat, exp, W + 1);
      end
      run_op(4'b0100, 8'd5, 8'd0, lat);
      exp = {8'hFF, 8'h05, 4'b0001};
      n_tests++;
      if (observe() !== exp || lat !== W + 1) begin
         n_fail++; $display("FAIL div_by_zero: got %h lat %0d want %h lat %0d", observe(), lat, exp, W + 1);
      end
      run_op(4'b1100, W'($urandom()), W'($urandom()), lat);
      n_tests++;
      if (observe() !== exp || lat !== 1) begin
         n_fail++; $display("FAIL nop_hold_err: got %h lat %0d want %h lat 1", observe(), lat, exp);
      end
      run_op(4'b0001, 8'h01, 8'h01, lat);
      exp = {8'h02, 8'h00, 4'b0000};
      n_tests++;
      if (observe() !== exp) begin n_fail++; $display("FAIL err_clear: got %h want %h", observe(), exp); end
      model_state = exp;
      $display("[TB] div checks done -> %h", observe());
   endtask

   task automatic test_back_to_back();
      res_t exp;
      @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         logic [3:0]   op = ($urandom_range(0, 4) == 0) ? 4'd13 : sc_ops[$urandom_range(0, 9)];
         logic [W-1:0] a  = W'($urandom());
         logic [W-1:0] b  = W'($urandom());
         bus.enable = 1'b1; bus.opcode = op; bus.regA = a; bus.regB = b;
         exp = model_op(op, a, b, model_state);
         model_state = exp;
         @(negedge clock);
         n_tests++;
         if (observe() !== exp || bus.pronto !== 1'b1) begin
            n_fail++; $display("FAIL b2b_%0d op=%h: got %h pronto %b want %h pronto 1", i, op, observe(), bus.pronto, exp);
         end
         $display("[TB] b2b op=%h a=%h b=%h -> %h", op, a, b, observe());
      end
      bus.enable = 1'b0;
      @(negedge clock);
      n_tests++;
      if (bus.pronto !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got pronto %b want 0", bus.pronto); end
   endtask

   task automatic test_abort_nop();
      int lat;
      bit seen = 1'b0;
      run_op(4'b1010, 8'h5A, 8'h00, lat);
      n_tests++;
      if (observe() !== {8'h5A, 8'h00, 4'b0000}) begin
         n_fail++; $display("FAIL pass_a: got %h want %h", observe(), {8'h5A, 8'h00, 4'b0000});
      end
      @(negedge clock);
      bus.enable = 1'b1; bus.opcode = 4'b0011; bus.regA = 8'hFF; bus.regB = 8'hFF;
      @(posedge clock);
      #1 bus.enable = 1'b0;
      repeat (3) @(posedge clock);          // three iteration edges done
      @(negedge clock);
      reset = 1'b1;                         // sampled at the fourth iteration edge
      @(negedge clock);
      n_tests++;
      if (observe() !== res_t'(0) || bus.busy !== 1'b0 || bus.pronto !== 1'b0) begin
         n_fail++; $display("FAIL abort: got %h busy %b pronto %b want 0 0 0", observe(), bus.busy, bus.pronto);
      end
      reset = 1'b0;
      model_state = '0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (bus.pronto === 1'b1) seen = 1'b1;
      end
      n_tests++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_pronto: got pronto seen %b want 0", seen); end
      run_op(4'b1100, W'($urandom()), W'($urandom()), lat);
      n_tests++;
      if (observe() !== model_state || lat !== 1) begin
         n_fail++; $display("FAIL nop_after_abort: got %h lat %0d want %h lat 1", observe(), lat, model_state);
      end
      $display("[TB] abort and nop -> %h", observe());
   endtask

   initial begin
      bus.enable = 1'b0; bus.opcode = '0; bus.regA = '0; bus.regB = '0;
      test_reset();
      test_add_sub();
      test_mul();
      test_div();
      test_back_to_back();
      test_abort_nop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
Parametrised successor of the processor's single-cycle ALU: same opcode map, generalised to WIDTH bits, with an enable/busy/pronto handshake toward the control unit. Logic ops and add/sub complete in one cycle. Multiply and divide run as iterative shift-add and restoring-divide sequencers over WIDTH cycles. Adds status flags and a high-half/remainder output.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 4..32.

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  start request; sampled only when busy=0
opcode  input  4  operation select, captured with enable
regA  input  WIDTH  operand A, captured with enable
regB  input  WIDTH  operand B, captured with enable
saidaULA  output  WIDTH  result: low half for MUL, quotient for DIV
saidaAlta  output  WIDTH  MUL high half, DIV remainder; 0 for other ops
busy  output  1  high while a MUL/DIV is iterating
pronto  output  1  one-cycle pulse: result and flags valid
zero  output  1  saidaULA==0 for the last completed op
carry  output  1  ADD carry-out; SUB borrow (regA<regB unsigned); 0 otherwise
overflow  output  1  signed overflow for ADD/SUB; MUL: saidaAlta!=0; 0 otherwise
erroDiv  output  1  last completed op was DIV with regB==0

Behaviour:
- Reset (sync, active-high): all outputs 0, FSM to OCIOSO, iteration counter 0. Reset wins over enable. Reset mid-MUL/DIV aborts the operation with no pronto pulse.
- FSM states:
  - OCIOSO: enable=1 with a single-cycle opcode computes the result at that edge. pronto=1 for the next cycle only. Latency 1.
  - OCIOSO: enable=1 with MUL (0011) or DIV (0100) latches operands, sets busy=1, and moves to ITERA.
  - ITERA: one bit per clock. After exactly WIDTH cycles it writes outputs and flags, drops busy, pulses pronto, and returns to OCIOSO. Total latency: pronto is high in cycle N+WIDTH+1 when enable is sampled at edge N.
- Handshake:
  - enable while busy=1 is ignored (no queueing). Operand/opcode changes during ITERA have no effect.
  - Back-to-back single-cycle ops are allowed every cycle; pronto stays high continuously.
- Opcodes, all unsigned, results truncated to WIDTH:
  - 0000 zero; 0001 A+B; 0010 A-B; 0011 A*B (2*WIDTH product split saidaAlta:saidaULA); 0100 A/B (quotient, remainder)
  - 0101 AND; 0110 OR; 0111 NOT A; 1000 XOR; 1001 XNOR; 1010 pass A; 1011 pass B
- 1100-1111 are NOPs reserved for control-unit RAM moves: saidaULA, saidaAlta and flags held; pronto still pulses once.
- DIV by zero: saidaULA = all ones, saidaAlta = regA, erroDiv=1, still WIDTH cycles. erroDiv clears on the next completed non-NOP op.
- Outputs and flags change only at completion (pronto edge) and hold otherwise. zero/carry/overflow are recomputed for every non-NOP op.
- saidaAlta is 0 for all ops except MUL/DIV.

Test Plan:
- Reset: drive reset=1 with enable=1, opcode=0001 -> all outputs 0, pronto stays 0.
- ADD, WIDTH=8: A=0xFF, B=0x01, opcode 0001 -> next cycle saidaULA=0x00, zero=1, carry=1, overflow=0, pronto one cycle.
- SUB: A=0x80, B=0x01 -> saidaULA=0x7F, overflow=1, carry=0.
- MUL: A=0xFF, B=0xFF -> busy for 8 cycles; pronto at cycle N+9; saidaAlta=0xFE, saidaULA=0x01, overflow=1. A second enable during busy (opcode 0001) is ignored.
- DIV: A=200, B=7 -> saidaULA=28, saidaAlta=4, erroDiv=0. Then A=5, B=0 -> saidaULA=0xFF, saidaAlta=5, erroDiv=1.
- Abort and NOP:
  - Assert reset at the 4th ITERA cycle of a MUL -> busy=0, no pronto, outputs 0.
  - Then opcode 1100 -> outputs held, pronto pulses.
